// File: rtl/regfile.sv
// rtl/regfile.sv - 31x32 integer register file with power-up clear sequence and write bypass
//
// Purpose: x1..x31 storage for the pipeline. After reset the block walks x1..x31
// loading CLR_VAL, one register per cycle, before it accepts writes.
//
// Ports:
//   clk_i         sole clock, rising edge
//   rst_i         synchronous active-high reset
//   rf_wr_en_i    writeback write enable
//   rf_wr_reg_i   writeback register index
//   rf_wr_data_i  writeback data
//   rs1_i/rs2_i   read port indices
//   rs1_data_o    read port 1 data (combinational)
//   rs2_data_o    read port 2 data (combinational)
//   ready_o       high once the clear sequence has finished
//   clr_idx_o     current clear index, 0 once running
module regfile #(
    parameter bit          BYPASS_EN = 1'b1,
    parameter logic [31:0] CLR_VAL   = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rf_wr_en_i,
    input  logic [4:0]  rf_wr_reg_i,
    input  logic [31:0] rf_wr_data_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o,
    output logic        ready_o,
    output logic [4:0]  clr_idx_o
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  clr_idx;
    logic [4:0]  clr_idx_nxt;
    logic        run;
    logic        wr_fire;

    // x0 has no storage; its reads are forced to zero on the read path.
    logic [31:0] regs [1:31];

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_CLEAR;
            clr_idx <= 5'd1;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        case (state)
            ST_CLEAR: begin
                if (clr_idx == 5'd31) begin
                    state_nxt   = ST_RUN;
                    clr_idx_nxt = 5'd0;
                end else begin
                    clr_idx_nxt = clr_idx + 5'd1;
                end
            end
            ST_RUN: begin
                clr_idx_nxt = 5'd0;
            end
        endcase
    end

    // Output logic. rst_i is folded in combinationally so the outputs already
    // show the reset values during the cycle reset is asserted, and a write
    // presented alongside reset can neither commit nor be bypassed.
    always_comb begin
        run       = (state == ST_RUN) && !rst_i;
        ready_o   = run;
        clr_idx_o = rst_i ? 5'd1 : clr_idx;
        wr_fire   = run && rf_wr_en_i && (rf_wr_reg_i != 5'd0);
    end

    // Storage: the clear sequence owns the write port until RUN.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state == ST_CLEAR) begin
                regs[clr_idx] <= CLR_VAL;
            end else if (wr_fire) begin
                regs[rf_wr_reg_i] <= rf_wr_data_i;
            end
        end
    end

    // Read port 1
    always_comb begin
        rs1_data_o = 32'h0;
        if (run && (rs1_i != 5'd0)) begin
            if (BYPASS_EN && wr_fire && (rf_wr_reg_i == rs1_i)) begin
                rs1_data_o = rf_wr_data_i;
            end else begin
                rs1_data_o = regs[rs1_i];
            end
        end
    end

    // Read port 2
    always_comb begin
        rs2_data_o = 32'h0;
        if (run && (rs2_i != 5'd0)) begin
            if (BYPASS_EN && wr_fire && (rf_wr_reg_i == rs2_i)) begin
                rs2_data_o = rf_wr_data_i;
            end else begin
                rs2_data_o = regs[rs2_i];
            end
        end
    end

endmodule

// File: tb/tb_regfile.sv
// tb/tb_regfile.sv - randomized self-checking bench for regfile, bypass and non-bypass builds
module tb_regfile;

    localparam logic [31:0] CLR_A = 32'hC1EA_0001;
    localparam logic [31:0] CLR_B = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] a_rs1, a_rs2, b_rs1, b_rs2;
    logic        a_rdy, b_rdy;
    logic [4:0]  a_idx, b_idx;

    always #5 clk = ~clk;

    regfile #(.BYPASS_EN(1'b1), .CLR_VAL(CLR_A)) u_byp (
        .clk_i(clk), .rst_i(rst), .rf_wr_en_i(wr_en), .rf_wr_reg_i(wr_reg),
        .rf_wr_data_i(wr_data), .rs1_i(rs1), .rs2_i(rs2),
        .rs1_data_o(a_rs1), .rs2_data_o(a_rs2), .ready_o(a_rdy), .clr_idx_o(a_idx)
    );

    regfile #(.BYPASS_EN(1'b0), .CLR_VAL(CLR_B)) u_nobyp (
        .clk_i(clk), .rst_i(rst), .rf_wr_en_i(wr_en), .rf_wr_reg_i(wr_reg),
        .rf_wr_data_i(wr_data), .rs1_i(rs1), .rs2_i(rs2),
        .rs1_data_o(b_rs1), .rs2_data_o(b_rs2), .ready_o(b_rdy), .clr_idx_o(b_idx)
    );

    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model: architectural register contents and clear progress.
    logic [31:0] mdl_a [32];
    logic [31:0] mdl_b [32];
    int          clr_cnt   = 0;
    bit          mdl_ready = 1'b0;

    bit          seen_ready;
    logic [31:0] last_a1, last_a2, last_b1, last_b2;
    int          n_clr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] idx,
                                           input logic [31:0] stored);
        if (!mdl_ready || rst || idx == 5'd0) return 32'h0;
        if (byp && wr_en && wr_reg == idx) return wr_data;
        return stored;
    endfunction

    // Apply one cycle of inputs, check outputs mid-cycle, advance the model at the edge.
    task automatic do_cycle(input bit r, input bit we, input logic [4:0] wreg,
                            input logic [31:0] wdat, input logic [4:0] r1, input logic [4:0] r2);
        logic [4:0] exp_idx;
        rst = r; wr_en = we; wr_reg = wreg; wr_data = wdat; rs1 = r1; rs2 = r2;
        #4;
        exp_idx = r ? 5'd1 : (mdl_ready ? 5'd0 : 5'(clr_cnt + 1));
        check("a_ready", 32'(a_rdy), 32'(mdl_ready && !r));
        check("b_ready", 32'(b_rdy), 32'(mdl_ready && !r));
        check("a_clr_idx", 32'(a_idx), 32'(exp_idx));
        check("b_clr_idx", 32'(b_idx), 32'(exp_idx));
        check("a_rs1", a_rs1, exp_rd(1'b1, r1, mdl_a[r1]));
        check("a_rs2", a_rs2, exp_rd(1'b1, r2, mdl_a[r2]));
        check("b_rs1", b_rs1, exp_rd(1'b0, r1, mdl_b[r1]));
        check("b_rs2", b_rs2, exp_rd(1'b0, r2, mdl_b[r2]));
        seen_ready = a_rdy;
        last_a1 = a_rs1; last_a2 = a_rs2; last_b1 = b_rs1; last_b2 = b_rs2;
        @(posedge clk);
        if (r) begin
            mdl_ready = 1'b0;
            clr_cnt   = 0;
        end else if (!mdl_ready) begin
            clr_cnt++;
            if (clr_cnt == 31) begin
                mdl_ready = 1'b1;
                for (int i = 1; i < 32; i++) begin
                    mdl_a[i] = CLR_A;
                    mdl_b[i] = CLR_B;
                end
            end
        end else if (we && wreg != 5'd0) begin
            mdl_a[wreg] = wdat;
            mdl_b[wreg] = wdat;
        end
        #1;
    endtask

    task automatic rand_cycle();
        logic [4:0] wreg;
        logic [4:0] r1;
        logic [4:0] r2;
        wreg = 5'($urandom_range(0, 31));
        r1   = ($urandom_range(0, 3) == 0) ? wreg : 5'($urandom_range(0, 31));
        r2   = ($urandom_range(0, 3) == 0) ? wreg : 5'($urandom_range(0, 31));
        do_cycle(1'b0, 1'($urandom_range(0, 1)), wreg, $urandom, r1, r2);
    endtask

    // Run from reset release until ready; counts cycles with ready low.
    // A write of x3 is presented at clear cycle 5 and must not survive.
    task automatic run_clear(output int n);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (c == 4) do_cycle(1'b0, 1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd3);
            else        rand_cycle();
            if (seen_ready) break;
            n++;
        end
    endtask

    task automatic read_all();
        for (int i = 0; i < 32; i++) do_cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mdl_a[i] = 32'h0;
            mdl_b[i] = 32'h0;
        end
        rst = 1'b1; wr_en = 1'b0; wr_reg = 5'd0; wr_data = 32'h0; rs1 = 5'd0; rs2 = 5'd0;
        @(posedge clk);
        #1;

        // Reset held, with a write that must be discarded
        repeat (3) do_cycle(1'b1, 1'b1, 5'd4, 32'h1111_2222, 5'd4, 5'd4);

        run_clear(n_clr);
        check("clear_len", 32'(n_clr), 32'd31);
        read_all();
        do_cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4);
        check("x3_after_clear_a", last_a1, CLR_A);
        check("x4_after_rst_wr_b", last_b2, CLR_B);

        // Write then read next cycle
        do_cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
        do_cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd6);
        check("x5_rd_a", last_a1, 32'hDEADBEEF);
        check("x6_rd_a", last_a2, CLR_A);
        check("x5_rd_b", last_b1, 32'hDEADBEEF);

        // Bypass: both ports same index, same cycle as write
        do_cycle(1'b0, 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7);
        check("byp_a_rs1", last_a1, 32'h12345678);
        check("byp_a_rs2", last_a2, 32'h12345678);
        check("nobyp_b_rs1", last_b1, CLR_B);
        check("nobyp_b_rs2", last_b2, CLR_B);
        do_cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
        check("x7_next_b", last_b1, 32'h12345678);

        // x0 is hardwired to zero
        do_cycle(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        check("x0_same_a", last_a1, 32'h0);
        check("x0_same_b", last_b1, 32'h0);
        do_cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        check("x0_next_a", last_a1, 32'h0);

        repeat (400) rand_cycle();

        // Reset pulse at clear cycle 10 restarts the full sequence
        do_cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
        repeat (9) rand_cycle();
        do_cycle(1'b1, 1'b1, 5'd9, 32'h0BAD_0BAD, 5'd9, 5'd9);
        run_clear(n_clr);
        check("clear_len_midrst", 32'(n_clr), 32'd31);
        read_all();

        repeat (200) rand_cycle();

        // Reset from RUN overwrites everything with the clear value
        repeat (2) do_cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd5);
        run_clear(n_clr);
        check("clear_len_run_rst", 32'(n_clr), 32'd31);
        read_all();
        do_cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd7);
        check("x5_recleared_a", last_a1, CLR_A);
        check("x7_recleared_b", last_b2, CLR_B);

        repeat (100) rand_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
